// File: rtl/mgt_tx_port_pkg.sv
// Shared definitions for the MGT transmit port: flit geometry, port codes and
// the arbiter source selector.
package mgt_tx_port_pkg;

  localparam int unsigned FLIT_SIZE            = 82;
  localparam int unsigned VALID_BIT            = 81;
  localparam int unsigned DEFAULT_INIT_CREDITS = 16;

  typedef enum logic [2:0] {
    DIR_INJECT = 3'd0,
    DIR_XPOS   = 3'd1,
    DIR_XNEG   = 3'd2,
    DIR_YPOS   = 3'd3,
    DIR_YNEG   = 3'd4,
    DIR_ZPOS   = 3'd5,
    DIR_ZNEG   = 3'd6,
    DIR_EJECT  = 3'd7
  } dir_e;

  typedef enum logic {
    SRC_SW  = 1'b0,
    SRC_INJ = 1'b1
  } src_e;

endpackage

// File: rtl/mgt_tx_port_fifo.sv
// Power-of-two synchronous FIFO with fall-through read data; a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module tx_fifo #(
  parameter  int unsigned WIDTH = 82,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mgt_tx_port.sv
// MGT transmit port: merges switch and inject flits into one credit-limited
// output stream with round-robin arbitration between the two sources.
module mgt_tx_port
  #(
  parameter int unsigned FLIT_SIZE    = mgt_tx_port_pkg::FLIT_SIZE,
  parameter int unsigned VALID_BIT    = mgt_tx_port_pkg::VALID_BIT,
  parameter int unsigned SW_Q_DEPTH   = 4,
  parameter int unsigned INJ_Q_DEPTH  = 4,
  parameter int unsigned INIT_CREDITS = mgt_tx_port_pkg::DEFAULT_INIT_CREDITS,
  parameter int unsigned CREDIT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] sw_flit,
  input  logic                 sw_valid,
  output logic                 sw_afull,
  input  logic [FLIT_SIZE-1:0] inject_flit,
  input  logic                 inject_valid,
  output logic                 inject_avail,
  input  logic                 credit_return,
  output logic [FLIT_SIZE-1:0] out_flit,
  output logic                 out_valid,
  output logic [CREDIT_W-1:0]  credit_count,
  output logic [1:0]           err
);
  import mgt_tx_port_pkg::*;

  localparam int unsigned SW_CW  = $clog2(SW_Q_DEPTH) + 1;
  localparam int unsigned INJ_CW = $clog2(INJ_Q_DEPTH) + 1;
  localparam logic [CREDIT_W-1:0] INIT_CNT = CREDIT_W'(INIT_CREDITS);

  if (VALID_BIT >= FLIT_SIZE || SW_Q_DEPTH < 4 || INJ_Q_DEPTH < 2 ||
      (SW_Q_DEPTH & (SW_Q_DEPTH - 1)) != 0 ||
      (INJ_Q_DEPTH & (INJ_Q_DEPTH - 1)) != 0 ||
      (64'd1 << CREDIT_W) <= 64'(INIT_CREDITS)) begin : g_bad_params
    $error("mgt_tx_port: illegal parameterisation");
  end

  logic [FLIT_SIZE-1:0] sw_dout;
  logic [FLIT_SIZE-1:0] inj_dout;
  logic                 sw_full;
  logic                 sw_empty;
  logic [SW_CW-1:0]     sw_count;
  logic                 inj_full;
  logic                 inj_empty;
  logic [INJ_CW-1:0]    inj_count;
  logic                 unused_inj_count;
  logic                 inj_push;
  logic                 credit_ok;
  logic                 sw_elig;
  logic                 inj_elig;
  logic                 grant_sw;
  logic                 grant_inj;
  logic                 send;
  src_e                 rr;

  assign unused_inj_count = ^inj_count;

  assign inject_avail = !inj_full;
  assign inj_push     = inject_valid && inject_avail;
  assign sw_afull     = (32'(sw_count) >= SW_Q_DEPTH - 32'd2);

  tx_fifo #(.WIDTH(FLIT_SIZE), .DEPTH(SW_Q_DEPTH)) u_sw_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (sw_valid),
    .din   (sw_flit),
    .pop   (grant_sw),
    .dout  (sw_dout),
    .full  (sw_full),
    .empty (sw_empty),
    .count (sw_count)
  );

  tx_fifo #(.WIDTH(FLIT_SIZE), .DEPTH(INJ_Q_DEPTH)) u_inj_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inj_push),
    .din   (inject_flit),
    .pop   (grant_inj),
    .dout  (inj_dout),
    .full  (inj_full),
    .empty (inj_empty),
    .count (inj_count)
  );

  assign credit_ok = (credit_count != '0);
  assign sw_elig   = !sw_empty && credit_ok;
  assign inj_elig  = !inj_empty && credit_ok;

  always_comb begin
    grant_sw  = 1'b0;
    grant_inj = 1'b0;
    if (sw_elig && inj_elig) begin
      if (rr == SRC_SW) grant_sw  = 1'b1;
      else              grant_inj = 1'b1;
    end else begin
      grant_sw  = sw_elig;
      grant_inj = inj_elig;
    end
  end

  assign send = grant_sw || grant_inj;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_flit     <= '0;
      out_valid    <= 1'b0;
      credit_count <= INIT_CNT;
      rr           <= SRC_SW;
      err          <= '0;
    end else begin
      out_valid <= send;
      if (grant_sw)       out_flit <= sw_dout;
      else if (grant_inj) out_flit <= inj_dout;
      else                out_flit <= '0;

      // Priority always passes to the source that did not send this cycle.
      if (send) rr <= grant_sw ? SRC_INJ : SRC_SW;

      if (credit_return && !send) begin
        if (credit_count == INIT_CNT) err[1] <= 1'b1;
        else                          credit_count <= credit_count + CREDIT_W'(1);
      end else if (send && !credit_return) begin
        credit_count <= credit_count - CREDIT_W'(1);
      end

      if (sw_valid && sw_full && !grant_sw) err[0] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mgt_tx_port.sv
// Self-checking bench for mgt_tx_port against a queue-based reference model.
module tb_mgt_tx_port;

  localparam int unsigned FW    = 82;
  localparam int unsigned SWD   = 4;
  localparam int unsigned INJD  = 4;
  localparam int unsigned INITC = 16;
  localparam int unsigned CW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] sw_flit;
  logic          sw_valid;
  logic          sw_afull;
  logic [FW-1:0] inject_flit;
  logic          inject_valid;
  logic          inject_avail;
  logic          credit_return;
  logic [FW-1:0] out_flit;
  logic          out_valid;
  logic [CW-1:0] credit_count;
  logic [1:0]    err;

  mgt_tx_port #(
    .FLIT_SIZE(FW), .VALID_BIT(81), .SW_Q_DEPTH(SWD), .INJ_Q_DEPTH(INJD),
    .INIT_CREDITS(INITC), .CREDIT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .sw_flit(sw_flit), .sw_valid(sw_valid), .sw_afull(sw_afull),
    .inject_flit(inject_flit), .inject_valid(inject_valid), .inject_avail(inject_avail),
    .credit_return(credit_return),
    .out_flit(out_flit), .out_valid(out_valid),
    .credit_count(credit_count), .err(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [FW-1:0] m_sw[$];
  logic [FW-1:0] m_inj[$];
  int            m_cred;
  bit            m_inj_first;
  logic [1:0]    m_err;
  logic          m_ov;
  logic [FW-1:0] m_of;
  string         phase;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("out_valid",    128'(out_valid),    128'(m_ov));
    chk("out_flit",     128'(out_flit),     128'(m_of));
    chk("credit_count", 128'(credit_count), 128'(m_cred));
    chk("err",          128'(err),          128'(m_err));
    chk("sw_afull",     128'(sw_afull),     128'(m_sw.size() >= int'(SWD) - 2));
    chk("inject_avail", 128'(inject_avail), 128'(m_inj.size() < int'(INJD)));
  endtask

  task automatic model_reset();
    m_sw.delete();
    m_inj.delete();
    m_cred      = INITC;
    m_inj_first = 1'b0;
    m_err       = '0;
    m_ov        = 1'b0;
    m_of        = '0;
  endtask

  function automatic logic [FW-1:0] rand_flit();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[FW-1:0];
  endfunction

  // One clock cycle: apply inputs at the falling edge, predict, check after the rising edge.
  task automatic step(input logic sv, input logic [FW-1:0] sf,
                      input logic iv, input logic [FW-1:0] inf, input logic cr);
    bit e_s, e_i, gs, gi, acc_i;
    sw_valid = sv; sw_flit = sf; inject_valid = iv; inject_flit = inf; credit_return = cr;
    e_s   = (m_sw.size() > 0) && (m_cred > 0);
    e_i   = (m_inj.size() > 0) && (m_cred > 0);
    acc_i = iv && (m_inj.size() < int'(INJD));
    gs    = e_s && (!e_i || !m_inj_first);
    gi    = e_i && !gs;
    m_ov  = gs || gi;
    if (gs)      m_of = m_sw.pop_front();
    else if (gi) m_of = m_inj.pop_front();
    else         m_of = '0;
    if (sv) begin
      if (m_sw.size() < int'(SWD)) m_sw.push_back(sf);
      else                         m_err[0] = 1'b1;
    end
    if (acc_i) m_inj.push_back(inf);
    if (cr && !m_ov) begin
      if (m_cred == int'(INITC)) m_err[1] = 1'b1;
      else                       m_cred++;
    end else if (!cr && m_ov) begin
      m_cred--;
    end
    if (m_ov) m_inj_first = gs;
    @(posedge clk);
    #1;
    check_outs();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    sw_valid = 0; inject_valid = 0; credit_return = 0; sw_flit = '0; inject_flit = '0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_outs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [FW-1:0] f0;
    rst = 1'b0;
    sw_valid = 0; inject_valid = 0; credit_return = 0; sw_flit = '0; inject_flit = '0;
    model_reset();
    phase = "reset";
    repeat (2) @(negedge clk);
    check_outs();
    rst = 1'b1;

    phase = "single";
    idle(4);
    f0 = 82'h2_0000_0000_0000_0000_0001;
    step(1'b1, f0, 1'b0, '0, 1'b0);
    chk("not_yet", 128'(out_valid), 128'(0));
    step(1'b0, '0, 1'b0, '0, 1'b0);
    chk("lat2_valid", 128'(out_valid), 128'(1));
    chk("lat2_flit",  128'(out_flit),  128'(f0));
    chk("lat2_cred",  128'(credit_count), 128'(15));
    idle(2);

    phase = "interleave";
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, FW'(32'h5000 + i), 1'b1, FW'(32'h1000 + i), 1'b0);
    idle(5);
    chk("cred_after6", 128'(credit_count), 128'(10));

    phase = "drain_credits";
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, rand_flit(), 1'b0, '0, 1'b0);
    idle(2);
    chk("cred_zero", 128'(credit_count), 128'(0));

    phase = "sw_overflow";
    for (int i = 0; i < 5; i++) step(1'b1, FW'(32'hA0 + i), 1'b0, '0, 1'b0);
    chk("err0_set", 128'(err[0]),  128'(1));
    chk("afull",    128'(sw_afull), 128'(1));

    phase = "inj_full";
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, FW'(32'hB0 + i), 1'b0);
    chk("avail_low", 128'(inject_avail), 128'(0));

    phase = "one_credit";
    step(1'b0, '0, 1'b0, '0, 1'b1);
    chk("no_send_same_cycle", 128'(out_valid), 128'(0));
    step(1'b0, '0, 1'b0, '0, 1'b0);
    chk("sent_after_return", 128'(out_valid), 128'(1));
    chk("cred_back_zero",    128'(credit_count), 128'(0));

    phase = "over_return";
    for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b0, '0, 1'b1);
    chk("err1_set", 128'(err[1]), 128'(1));
    chk("cred_cap", 128'(credit_count), 128'(INITC));

    phase = "random";
    do_reset();
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), rand_flit(), 1'($urandom_range(0, 1)), rand_flit(),
           1'($urandom_range(0, 9) < 4));

    phase = "mid_reset";
    for (int i = 0; i < 3; i++) step(1'b1, rand_flit(), 1'b1, rand_flit(), 1'b0);
    do_reset();
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
